if_rf_stage_reg: RTL

Parametrised successor of the IF/RF pipeline register. Carries instruction, PC and the IF-computed next-PC result from fetch to register-read. Adds what a bare D_FF bank lacks:
- a valid/ready handshake with a one-entry skid buffer, so downstream stalls never drop an instruction;
- flush with NOP-bubble insertion;
- a saturating stall-cycle counter for performance debug.

---
 rtl/if_rf_stage_reg_if.sv | 29 ++
 rtl/if_rf_stage_reg.sv | 87 ++++++++
 2 files changed

// File: rtl/if_rf_stage_reg_if.sv
// rtl/if_rf_stage_reg_if.sv - fetch-to-register-read payload and handshake bundle
interface if_rf_stage_reg_if #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 64,
  parameter int CNT_W   = 16
);
  logic [INSTR_W-1:0] instr_in;
  logic [ADDR_W-1:0]  pc_in;
  logic [ADDR_W-1:0]  norm_result_if;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic               out_ready;
  logic               out_valid;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_out;
  logic [ADDR_W-1:0]  norm_result;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output instr_in, pc_in, norm_result_if, in_valid, flush, out_ready,
    input  in_ready, out_valid, instr_out, pc_out, norm_result, stall_cnt
  );

  modport slave (
    input  instr_in, pc_in, norm_result_if, in_valid, flush, out_ready,
    output in_ready, out_valid, instr_out, pc_out, norm_result, stall_cnt
  );
endinterface

// File: rtl/if_rf_stage_reg.sv
// rtl/if_rf_stage_reg.sv - IF/RF pipeline register with skid buffer, flush and stall counter
module if_rf_stage_reg #(
  parameter int                 INSTR_W   = 32,
  parameter int                 ADDR_W    = 64,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F,
  parameter int                 CNT_W     = 16
) (
  input logic                clk,
  input logic                reset,
  if_rf_stage_reg_if.slave   bus
);

  logic               r_main_valid;
  logic [INSTR_W-1:0] r_main_instr;
  logic [ADDR_W-1:0]  r_main_pc;
  logic [ADDR_W-1:0]  r_main_norm;
  logic               r_skid_valid;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [ADDR_W-1:0]  r_skid_pc;
  logic [ADDR_W-1:0]  r_skid_norm;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic w_accept;
  logic w_drain;

  assign w_accept = bus.in_valid && !r_skid_valid && !bus.flush;
  assign w_drain  = r_main_valid && bus.out_ready;

  // Skid can only be occupied while main is, so an empty main implies an empty skid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_main_valid <= 1'b0;
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_main_norm  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_norm  <= '0;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid) begin
      if (w_accept) begin
        r_main_valid <= 1'b1;
        r_main_instr <= bus.instr_in;
        r_main_pc    <= bus.pc_in;
        r_main_norm  <= bus.norm_result_if;
      end
    end else if (w_drain) begin
      if (r_skid_valid) begin
        r_main_instr <= r_skid_instr;
        r_main_pc    <= r_skid_pc;
        r_main_norm  <= r_skid_norm;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_instr <= bus.instr_in;
        r_main_pc    <= bus.pc_in;
        r_main_norm  <= bus.norm_result_if;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= bus.instr_in;
      r_skid_pc    <= bus.pc_in;
      r_skid_norm  <= bus.norm_result_if;
    end
  end

  // Counts stalled cycles regardless of flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.in_ready    = !r_skid_valid;
  assign bus.out_valid   = r_main_valid;
  assign bus.instr_out   = r_main_valid ? r_main_instr : NOP_INSTR;
  assign bus.pc_out      = r_main_pc;
  assign bus.norm_result = r_main_norm;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule
